// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: owns the PC, drives the ROM, registered output slot to decode
module ifetch_stage #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  rom_illegal_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  fault_o,
    output logic                  halted_o,
    output logic [63:0]           fetch_count_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] r_slot_pc;
    logic [ADDR_WIDTH-1:0] w_slot_pc_nxt;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] w_inst_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic                  r_fault;
    logic                  w_fault_nxt;
    logic [63:0]           r_count;
    logic                  w_fire;
    logic                  w_slot_free;

    assign w_fire      = r_valid & ready_i;
    // The slot can be refilled in the same cycle decode consumes it.
    assign w_slot_free = ~r_valid | ready_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_slot_pc_nxt = r_slot_pc;
        w_inst_nxt    = r_inst;
        w_valid_nxt   = r_valid;
        w_fault_nxt   = r_fault;
        if (redirect_i) begin
            w_pc_nxt    = redirect_pc_i;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_RUN;
        end else if ((r_state == ST_RUN) && w_slot_free) begin
            w_slot_pc_nxt = r_pc;
            w_fault_nxt   = rom_illegal_i;
            w_valid_nxt   = 1'b1;
            w_inst_nxt    = rom_illegal_i ? '0 : rom_data_i;
            // A faulting fetch parks the PC on the bad address until execute redirects.
            if (rom_illegal_i) begin
                w_state_nxt = ST_HALT;
            end else begin
                w_pc_nxt = r_pc + ADDR_WIDTH'(4);
            end
        end else if ((r_state == ST_HALT) && w_fire) begin
            w_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_pc      <= RESET_PC;
            r_slot_pc <= '0;
            r_inst    <= '0;
            r_valid   <= 1'b0;
            r_fault   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_slot_pc <= w_slot_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_valid   <= w_valid_nxt;
            r_fault   <= w_fault_nxt;
            if (w_fire) begin
                r_count <= r_count + 64'd1;
            end
        end
    end

    assign rom_addr_o    = r_pc;
    assign valid_o       = r_valid;
    assign pc_o          = r_slot_pc;
    assign inst_o        = r_inst;
    assign fault_o       = r_fault;
    assign halted_o      = (r_state == ST_HALT);
    assign fetch_count_o = r_count;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - scoreboard bench for ifetch_stage with a program-order stream model
module tb_ifetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [63:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        rom_illegal_i;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        fault_o;
    logic        halted_o;
    logic [63:0] fetch_count_o;

    ifetch_stage #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(32),
        .RESET_PC  (64'h0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .rom_illegal_i(rom_illegal_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .fault_o      (fault_o),
        .halted_o     (halted_o),
        .fetch_count_o(fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM image: word at byte address a is 0x13 + 0x80*(a/4), giving 0x13, 0x93, 0x113, ...
    function automatic logic [31:0] rom_word(input logic [63:0] a);
        logic [63:0] t;
        t = (a >> 2) * 64'h80 + 64'h13;
        return t[31:0];
    endfunction

    assign rom_data_i    = rom_word(rom_addr_o);
    assign rom_illegal_i = (rom_addr_o[1:0] != 2'b00);

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] tb_count = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode must see: target, target+4, ... in order, ending with (and including) the first misaligned address.
    task automatic push_stream(input logic [63:0] start);
        logic [63:0] a;
        exp_t        e;
        sb_q.delete();
        a = start;
        for (int i = 0; i < 256; i++) begin
            e.pc    = a;
            e.fault = (a[1:0] != 2'b00);
            e.inst  = e.fault ? 32'h0 : rom_word(a);
            sb_q.push_back(e);
            if (e.fault) break;
            a = a + 64'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_redirect(input logic [63:0] t);
        redirect_i    = 1'b1;
        redirect_pc_i = t;
        tick();
        redirect_i = 1'b0;
        push_stream(t);
    endtask

    exp_t        m_e;
    logic        stall_v = 1'b0;
    logic [63:0] stall_pc;
    logic [31:0] stall_inst;
    logic        stall_fault;
    logic        after_fault = 1'b0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            tb_count    = '0;
            stall_v     = 1'b0;
            after_fault = 1'b0;
        end else begin
            check("count", fetch_count_o, tb_count);
            if (stall_v) begin
                check("stall_valid", 64'(valid_o), 64'd1);
                check("stall_pc", pc_o, stall_pc);
                check("stall_inst", 64'(inst_o), 64'(stall_inst));
                check("stall_fault", 64'(fault_o), 64'(stall_fault));
            end
            if (after_fault) begin
                check("halt_valid", 64'(valid_o), 64'd0);
                check("halt_flag", 64'(halted_o), 64'd1);
            end
            if (valid_o) begin
                check("halted_vs_fault", 64'(halted_o), 64'(fault_o));
            end
            if (valid_o && ready_i) begin
                tb_count = tb_count + 64'd1;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc %h expected no handshake", pc_o);
                end else begin
                    m_e = sb_q.pop_front();
                    check("slot_pc", pc_o, m_e.pc);
                    check("slot_inst", 64'(inst_o), 64'(m_e.inst));
                    check("slot_fault", 64'(fault_o), 64'(m_e.fault));
                    if (m_e.fault && !redirect_i) after_fault = 1'b1;
                end
            end
            stall_v     = valid_o && !ready_i && !redirect_i;
            stall_pc    = pc_o;
            stall_inst  = inst_o;
            stall_fault = fault_o;
            if (redirect_i) after_fault = 1'b0;
        end
    end

    initial begin
        int          r;
        int          gap;
        logic [63:0] t;

        rst_i   = 1'b1;
        ready_i = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_pc_o", pc_o, 64'd0);
        check("rst_inst", 64'(inst_o), 64'd0);
        check("rst_fault", 64'(fault_o), 64'd0);
        check("rst_halted", 64'(halted_o), 64'd0);
        check("rst_count", fetch_count_o, 64'd0);
        check("rst_rom_addr", rom_addr_o, 64'd0);

        rst_i = 1'b0;
        push_stream(64'h0);
        tick();
        check("first_valid", 64'(valid_o), 64'd1);
        check("first_pc", pc_o, 64'h0);
        check("first_inst", 64'(inst_o), 64'h13);
        tick();
        check("second_pc", pc_o, 64'h4);
        check("second_inst", 64'(inst_o), 64'h93);

        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_pc", pc_o, 64'h4);
            check("bp_inst", 64'(inst_o), 64'h93);
            check("bp_valid", 64'(valid_o), 64'd1);
            check("bp_rom_addr", rom_addr_o, 64'h8);
            check("bp_count", fetch_count_o, 64'd1);
        end
        ready_i = 1'b1;
        tick();
        check("after_bp_pc", pc_o, 64'h8);
        check("after_bp_inst", 64'(inst_o), 64'h113);
        tick();
        check("three_count", fetch_count_o, 64'd3);

        do_redirect(64'h40);
        check("redir_count", fetch_count_o, 64'd4);
        check("redir_valid", 64'(valid_o), 64'd0);
        tick();
        check("redir_slot_valid", 64'(valid_o), 64'd1);
        check("redir_slot_pc", pc_o, 64'h40);

        do_redirect(64'h42);
        check("mis_gap_valid", 64'(valid_o), 64'd0);
        tick();
        check("mis_valid", 64'(valid_o), 64'd1);
        check("mis_fault", 64'(fault_o), 64'd1);
        check("mis_inst", 64'(inst_o), 64'd0);
        check("mis_pc", pc_o, 64'h42);
        check("mis_halted", 64'(halted_o), 64'd1);
        tick();
        check("mis_drain_valid", 64'(valid_o), 64'd0);
        check("mis_drain_halted", 64'(halted_o), 64'd1);
        tick();
        check("mis_idle_valid", 64'(valid_o), 64'd0);
        do_redirect(64'h80);
        check("unhalt", 64'(halted_o), 64'd0);
        tick();
        check("unhalt_pc", pc_o, 64'h80);

        do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_rom_addr", rom_addr_o, 64'h0);
        tick();
        check("wrap_next_pc", pc_o, 64'h0);

        ready_i = 1'b0;
        tick();
        check("pre_rst_valid", 64'(valid_o), 64'd1);
        rst_i = 1'b1;
        tick();
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_count", fetch_count_o, 64'd0);
        check("mid_rst_rom_addr", rom_addr_o, 64'h0);
        rst_i = 1'b0;
        push_stream(64'h0);

        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            r       = int'($urandom_range(0, 99));
            ready_i = ($urandom_range(0, 3) != 0);
            if (r < 1) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                push_stream(64'h0);
                gap = 0;
            end else if (r < 6 || gap >= 100) begin
                case ($urandom_range(0, 3))
                    0: t = {$urandom, $urandom} & ~64'h3;
                    1: t = {$urandom, $urandom};
                    2: t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
                    default: t = 64'($urandom_range(0, 255)) * 64'd4;
                endcase
                do_redirect(t);
                gap = 0;
            end else begin
                tick();
                gap++;
            end
        end
        ready_i = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address. Captures the combinational ROM word and its misalignment flag into a registered output slot, then presents {pc, inst, fault} to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump/trap) and flushes the in-flight slot.

Parameters:
- ADDR_WIDTH, 64, PC / ROM address width
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- rom_addr_o  out  ADDR_WIDTH  ROM address; combinationally equal to the PC register
- rom_data_i  in  DATA_WIDTH  ROM read data, combinational from rom_addr_o
- rom_illegal_i  in  1  ROM misaligned-access flag, combinational from rom_addr_o
- redirect_i  in  1  redirect request from execute
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- valid_o  out  1  output slot holds an instruction for decode
- ready_i  in  1  decode accepts the slot this cycle
- pc_o  out  ADDR_WIDTH  PC of the slot instruction
- inst_o  out  DATA_WIDTH  instruction word (0 when fault_o=1)
- fault_o  out  1  slot carries an instruction-address-misaligned fault
- halted_o  out  1  fetch stopped after a fault, waiting for redirect
- fetch_count_o  out  64  count of completed output handshakes

Behaviour:
- Reset (rst_i=1 at clk edge):
  - pc <= RESET_PC, state <= RUN.
  - valid_o=0, pc_o=0, inst_o=0, fault_o=0, halted_o=0, fetch_count_o=0.
  - Reset mid-operation discards the slot with no handshake counted.
- Definitions:
  - fire = valid_o & ready_i.
  - slot_free = !valid_o | ready_i (the slot may be refilled in the same cycle it is consumed).
- State machine, two states: RUN and HALT.
  - halted_o = (state == HALT).
- Per-edge priority, highest first:
  1. Redirect (redirect_i=1):
     - pc <= redirect_pc_i, valid_o <= 0, state <= RUN.
     - No capture this cycle.
     - If fire is also high, the handshake still completes and fetch_count_o increments.
  2. Capture (state RUN and slot_free):
     - pc_o <= pc, fault_o <= rom_illegal_i, valid_o <= 1.
     - inst_o <= rom_illegal_i ? 0 : rom_data_i.
     - If rom_illegal_i=0: pc <= pc + 4, modulo 2^ADDR_WIDTH (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
     - If rom_illegal_i=1: pc unchanged, state <= HALT.
  3. HALT and fire: valid_o <= 0, pc held.
  4. Otherwise (stall: valid_o=1, ready_i=0): all slot outputs and pc hold stable.
- Handshake rules:
  - valid_o must not drop and slot outputs must not change while valid_o=1 and ready_i=0, except on redirect or reset.
  - fetch_count_o increments by 1 on every fire, including the fire that coincides with a redirect. Wraps modulo 2^64.
- Latency and throughput:
  - First valid_o=1 one cycle after rst_i deasserts.
  - First slot valid one cycle after a redirect, at the redirect target.
  - Throughput is one instruction per cycle while ready_i=1.
- Redirect while in HALT: returns to RUN; the next fetch is from redirect_pc_i.
- A misaligned redirect target produces a fault slot on the next cycle, then enters HALT.

Test Plan:
- Reset, RESET_PC=0, ready_i=1 held, ROM words 0x13, 0x93, 0x113: valid_o=1 from cycle 1; pc_o=0,4,8 with inst_o matching; fetch_count_o=3 after 3 cycles.
- Backpressure: ready_i=0 for 4 cycles with slot pc_o=4: pc_o=4 and inst_o stable, valid_o=1, rom_addr_o=8 held, fetch_count_o unchanged; after ready_i=1 the next pc_o is 8.
- Redirect to 0x40 while valid_o=1 and ready_i=1: fetch_count_o +1; next cycle valid_o=0; following cycle valid_o=1, pc_o=0x40.
- Redirect to 0x42: next slot fault_o=1, inst_o=0, pc_o=0x42; halted_o=1 thereafter; after fire valid_o=0 stays low; redirect to 0x80 clears halted_o, then pc_o=0x80.
- Wrap-around: redirect to 0xFFFF_FFFF_FFFF_FFFC: slot pc_o=...FFFC, then rom_addr_o=0 and next pc_o=0.
- Reset asserted with valid_o=1 and ready_i=0: next cycle valid_o=0, fetch_count_o=0, rom_addr_o=RESET_PC.
